rmt_dest_demux: RTL and testbench
=================================

RMT_DEST_DEMUX -- requirements
Module: rmt_dest_demux

Interface
REQ-001 The block SHALL be clocked by a single clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameters SHALL be as follows (name, default, meaning):
- DATA_WIDTH, 512: tdata width in bits.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width.
- USER_WIDTH, 8: tuser width.
- DEST_WIDTH, 2: tdest width.
- M_COUNT, 2: number of output ports, 1..2^DEST_WIDTH.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- s_axis_tdata, in, DATA_WIDTH: input beat data.
- s_axis_tkeep, in, KEEP_WIDTH: input byte enables.
- s_axis_tvalid, in, 1: input valid.
- s_axis_tready, out, 1: input ready.
- s_axis_tlast, in, 1: last beat of frame.
- s_axis_tuser, in, USER_WIDTH: sideband, passed through.
- s_axis_tdest, in, DEST_WIDTH: destination port index, sampled on the first beat only.
- m_axis_tdata, out, M_COUNT*DATA_WIDTH: per-port data; port i occupies slice i.
- m_axis_tkeep, out, M_COUNT*KEEP_WIDTH: per-port byte enables.
- m_axis_tvalid, out, M_COUNT: per-port valid.
- m_axis_tready, in, M_COUNT: per-port ready.
- m_axis_tlast, out, M_COUNT: per-port last.
- m_axis_tuser, out, M_COUNT*USER_WIDTH: per-port sideband.
- drop_count, out, 32: count of frames discarded for an out-of-range tdest; wraps.
- frame_count, out, M_COUNT*32: per-port count of forwarded frames; each wraps.

Function
REQ-004 An input beat SHALL be accepted only in a cycle where s_axis_tvalid and s_axis_tready are both 1.
REQ-005 The block SHALL implement three states: IDLE (awaiting first beat), FWD (frame locked to port d), DROP (discarding frame).
REQ-006 In IDLE, on acceptance of a beat with s_axis_tdest < M_COUNT, the block SHALL latch d = tdest and forward the beat to port d; the next state SHALL be FWD if tlast=0, IDLE if tlast=1.
REQ-007 In IDLE, on acceptance of a beat with s_axis_tdest >= M_COUNT, the block SHALL discard the beat; the next state SHALL be DROP if tlast=0, IDLE if tlast=1; drop_count SHALL increment by 1 on that first beat.
REQ-008 In FWD, every accepted beat SHALL be forwarded to port d regardless of the current s_axis_tdest; an accepted beat with tlast=1 SHALL return the state to IDLE.
REQ-009 In DROP, s_axis_tready SHALL be 1 and accepted beats SHALL be discarded; an accepted beat with tlast=1 SHALL return the state to IDLE.
REQ-010 Each output port SHALL have one registered output buffer; tdata, tkeep, tlast and tuser SHALL be copied unmodified; latency from acceptance to m_axis_tvalid SHALL be 1 cycle.
REQ-011 In IDLE and FWD, s_axis_tready SHALL be 1 when the target port buffer is empty, or is full and that port's m_axis_tready is 1 in the same cycle. The target port is s_axis_tdest in IDLE and d in FWD.
REQ-012 In IDLE with s_axis_tdest >= M_COUNT, s_axis_tready SHALL be 1.
REQ-013 A port buffer SHALL hold its contents stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-014 A simultaneous drain and refill of the same port SHALL sustain one beat per cycle with no bubble.
REQ-015 Ports other than the target SHALL drain independently; a stalled non-target port SHALL NOT block input.
REQ-016 frame_count[i] SHALL increment when a beat with tlast=1 is loaded into port i's buffer.
REQ-017 Counter overflow SHALL wrap from 0xFFFFFFFF to 0.
REQ-018 s_axis_tready SHALL NOT depend combinationally on s_axis_tvalid.

Reset
REQ-019 While rst_n=0, the outputs SHALL be: state IDLE, all m_axis_tvalid 0, s_axis_tready 0, drop_count 0, all frame_count 0, buffer data 0.
REQ-020 Reset asserted mid-frame SHALL discard any buffered beats. After rst_n deasserts, the first accepted beat SHALL be treated as a frame start (IDLE rules).
REQ-021 s_axis_tready SHALL rise no earlier than the first clock edge after rst_n deasserts.

Verification
REQ-022 Send a 4-beat frame with tdest=1 and all ready=1 -> port1 outputs 4 beats with tlast on beat 4, each 1 cycle after input; port0 tvalid stays 0; frame_count[1]=1.
REQ-023 Send a 3-beat frame with tdest=1 on beat 0 and tdest=0 on beats 1-2 -> all 3 beats appear on port1 only.
REQ-024 With M_COUNT=2, send a 5-beat frame with tdest=3 -> s_axis_tready=1 throughout, no output valid, drop_count=1; a following tdest=0 frame is delivered to port0.
REQ-025 Send a frame to port0 with m_axis_tready[0] toggling 1,0,0,1 -> data is held stable during stalls, s_axis_tready drops while the buffer is full, and no beat is lost or duplicated.
REQ-026 Stall port1, then send a tdest=0 frame -> the frame completes on port0 while the port1 buffer is held.
REQ-027 Assert rst_n=0 on beat 2 of a 6-beat FWD frame, then deassert and send a 1-beat tdest=0 frame -> all tvalid are 0 during reset, and the new 1-beat frame is delivered to port0 with tlast=1.

Source files
------------

// File: rtl/rmt_dest_demux.sv
// rmt_dest_demux: AXI-Stream frame demultiplexer. The first beat of each frame
// selects an output port through tdest; the rest of the frame follows it.
// Frames aimed at a port that does not exist are swallowed and counted.
// Each output port has a single registered beat buffer.
module rmt_dest_demux #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int USER_WIDTH = 8,
    parameter int DEST_WIDTH = 2,
    parameter int M_COUNT    = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    input  logic [USER_WIDTH-1:0]          s_axis_tuser,
    input  logic [DEST_WIDTH-1:0]          s_axis_tdest,
    output logic [M_COUNT*DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [M_COUNT*KEEP_WIDTH-1:0]  m_axis_tkeep,
    output logic [M_COUNT-1:0]             m_axis_tvalid,
    input  logic [M_COUNT-1:0]             m_axis_tready,
    output logic [M_COUNT-1:0]             m_axis_tlast,
    output logic [M_COUNT*USER_WIDTH-1:0]  m_axis_tuser,
    output logic [31:0]                    drop_count,
    output logic [M_COUNT*32-1:0]          frame_count
);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t                  state, state_nxt;
    logic [DEST_WIDTH-1:0]   dest_lock;
    logic [DEST_WIDTH-1:0]   tgt;
    logic                    rst_done;
    logic                    in_range;
    logic                    port_ok;
    logic                    rdy;
    logic                    fwd_beat;
    logic                    drop_first;
    logic [M_COUNT-1:0]      load;

    logic [DATA_WIDTH-1:0]   data_p1 [M_COUNT];
    logic [KEEP_WIDTH-1:0]   keep_p1 [M_COUNT];
    logic [USER_WIDTH-1:0]   user_p1 [M_COUNT];
    logic [M_COUNT-1:0]      last_p1;
    logic [M_COUNT-1:0]      vld_p1;
    logic [31:0]             frame_cnt [M_COUNT];

    // A tdest value only names a real port when it is below M_COUNT.
    assign in_range = (32'(s_axis_tdest) < 32'(M_COUNT));

    // While waiting for a frame start the live tdest picks the port; mid-frame the latched one does.
    assign tgt = (state == IDLE) ? s_axis_tdest : dest_lock;

    // Ready from the target port: its buffer is empty or is being drained this cycle.
    always_comb begin
        port_ok = 1'b0;
        for (int i = 0; i < M_COUNT; i++) begin
            if (tgt == DEST_WIDTH'(i)) port_ok = !vld_p1[i] || m_axis_tready[i];
        end
    end

    // Next-state and handshake decode; rdy never looks at s_axis_tvalid.
    always_comb begin
        state_nxt  = state;
        rdy        = 1'b0;
        fwd_beat   = 1'b0;
        drop_first = 1'b0;
        case (state)
            IDLE: begin
                rdy = rst_done && (!in_range || port_ok);
                if (s_axis_tvalid && rdy) begin
                    if (in_range) begin
                        fwd_beat  = 1'b1;
                        state_nxt = s_axis_tlast ? IDLE : FWD;
                    end else begin
                        drop_first = 1'b1;
                        state_nxt  = s_axis_tlast ? IDLE : DROP;
                    end
                end
            end
            FWD: begin
                rdy = rst_done && port_ok;
                if (s_axis_tvalid && rdy) begin
                    fwd_beat = 1'b1;
                    if (s_axis_tlast) state_nxt = IDLE;
                end
            end
            DROP: begin
                rdy = rst_done;
                if (s_axis_tvalid && rdy && s_axis_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_axis_tready = rdy;

    // Per-port load strobe for the beat being forwarded this cycle.
    always_comb begin
        load = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            load[i] = fwd_beat && (tgt == DEST_WIDTH'(i));
        end
    end

    // Frame state, latched destination, and the one-cycle post-reset hold-off on ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dest_lock <= '0;
            rst_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            rst_done <= 1'b1;
            if (state == IDLE && fwd_beat) dest_lock <= s_axis_tdest;
        end
    end

    // ---- stage p1: per-port output buffers (load wins over drain, so refill has no bubble) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= '0;
            last_p1 <= '0;
            for (int i = 0; i < M_COUNT; i++) begin
                data_p1[i] <= '0;
                keep_p1[i] <= '0;
                user_p1[i] <= '0;
            end
        end else begin
            for (int i = 0; i < M_COUNT; i++) begin
                if (load[i]) begin
                    vld_p1[i]  <= 1'b1;
                    data_p1[i] <= s_axis_tdata;
                    keep_p1[i] <= s_axis_tkeep;
                    user_p1[i] <= s_axis_tuser;
                    last_p1[i] <= s_axis_tlast;
                end else if (m_axis_tready[i]) begin
                    vld_p1[i] <= 1'b0;
                end
            end
        end
    end

    // Frame and drop statistics; both wrap naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
            for (int i = 0; i < M_COUNT; i++) frame_cnt[i] <= '0;
        end else begin
            if (drop_first) drop_count <= drop_count + 32'd1;
            for (int i = 0; i < M_COUNT; i++) begin
                if (load[i] && s_axis_tlast) frame_cnt[i] <= frame_cnt[i] + 32'd1;
            end
        end
    end

    assign m_axis_tvalid = vld_p1;
    assign m_axis_tlast  = last_p1;

    for (genvar g = 0; g < M_COUNT; g++) begin : g_out
        assign m_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH] = data_p1[g];
        assign m_axis_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH] = keep_p1[g];
        assign m_axis_tuser[g*USER_WIDTH +: USER_WIDTH] = user_p1[g];
        assign frame_count[g*32 +: 32]                  = frame_cnt[g];
    end

endmodule

// File: tb/tb_rmt_dest_demux.sv
// tb_rmt_dest_demux: frame-level reference model with per-port expected-beat
// queues, compared against the DUT on every falling edge, plus directed
// scenarios with literal expectations and a randomized traffic phase.
module tb_rmt_dest_demux;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int UW = 8;
    localparam int DSW = 2;
    localparam int M  = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DW-1:0]     s_axis_tdata;
    logic [KW-1:0]     s_axis_tkeep;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [UW-1:0]     s_axis_tuser;
    logic [DSW-1:0]    s_axis_tdest;
    logic [M*DW-1:0]   m_axis_tdata;
    logic [M*KW-1:0]   m_axis_tkeep;
    logic [M-1:0]      m_axis_tvalid;
    logic [M-1:0]      m_axis_tready = 2'b11;
    logic [M-1:0]      m_axis_tlast;
    logic [M*UW-1:0]   m_axis_tuser;
    logic [31:0]       drop_count;
    logic [M*32-1:0]   frame_count;

    rmt_dest_demux #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .DEST_WIDTH(DSW), .M_COUNT(M)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .s_axis_tdest(s_axis_tdest),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .drop_count(drop_count), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int stalls = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endfunction

    // ---------------- reference model ----------------
    beat_t       exp_q [M][$];
    int          m_mode = 0;      // 0 awaiting frame start, 1 forwarding, 2 discarding
    int          m_d    = 0;
    logic [31:0] m_drop = 0;
    logic [31:0] m_fc [M];
    bit          armed  = 0;

    // A clock edge seen with reset released arms the input side.
    always @(posedge clk) armed = rst_n;

    task automatic model_accept();
        beat_t b;
        b.data = s_axis_tdata; b.keep = s_axis_tkeep; b.last = s_axis_tlast; b.user = s_axis_tuser;
        if (m_mode == 0) begin
            if (int'(s_axis_tdest) < M) begin
                m_d = int'(s_axis_tdest);
                exp_q[m_d].push_back(b);
                if (b.last) m_fc[m_d] = m_fc[m_d] + 1;
                m_mode = b.last ? 0 : 1;
            end else begin
                m_drop = m_drop + 1;
                m_mode = b.last ? 0 : 2;
            end
        end else if (m_mode == 1) begin
            exp_q[m_d].push_back(b);
            if (b.last) begin
                m_fc[m_d] = m_fc[m_d] + 1;
                m_mode = 0;
            end
        end else if (b.last) begin
            m_mode = 0;
        end
    endtask

    // Compare every cycle, then apply the handshakes that occur at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < M; i++) begin
                exp_q[i].delete();
                m_fc[i] = 0;
            end
            m_mode = 0;
            m_drop = 0;
            chk("rst_tvalid", 64'(m_axis_tvalid), 0);
            chk("rst_tready", 64'(s_axis_tready), 0);
            chk("rst_drop",   64'(drop_count), 0);
            chk("rst_fcount", frame_count, 0);
            chk("rst_tdata",  m_axis_tdata, 0);
        end else begin
            bit er;
            int tg;
            for (int i = 0; i < M; i++) begin
                chk($sformatf("tvalid%0d", i), 64'(m_axis_tvalid[i]), 64'(exp_q[i].size() != 0));
                if (exp_q[i].size() != 0) begin
                    chk($sformatf("tdata%0d", i), 64'(m_axis_tdata[i*DW +: DW]), 64'(exp_q[i][0].data));
                    chk($sformatf("tkeep%0d", i), 64'(m_axis_tkeep[i*KW +: KW]), 64'(exp_q[i][0].keep));
                    chk($sformatf("tuser%0d", i), 64'(m_axis_tuser[i*UW +: UW]), 64'(exp_q[i][0].user));
                    chk($sformatf("tlast%0d", i), 64'(m_axis_tlast[i]), 64'(exp_q[i][0].last));
                end
                chk($sformatf("fcount%0d", i), 64'(frame_count[i*32 +: 32]), 64'(m_fc[i]));
            end
            chk("drop_count", 64'(drop_count), 64'(m_drop));
            if (!armed) er = 0;
            else if (m_mode == 2) er = 1;
            else begin
                tg = (m_mode == 0) ? int'(s_axis_tdest) : m_d;
                if (tg >= M) er = 1;
                else er = (exp_q[tg].size() == 0) || m_axis_tready[tg];
            end
            chk("s_tready", 64'(s_axis_tready), 64'(er));
            for (int i = 0; i < M; i++)
                if (exp_q[i].size() != 0 && m_axis_tready[i]) void'(exp_q[i].pop_front());
            if (s_axis_tvalid && s_axis_tready) model_accept();
        end
    end

    // ---------------- output-side ready driver ----------------
    logic [M-1:0] rdy_pat [$];
    logic [M-1:0] rdy_const = 2'b11;
    bit           rdy_rand  = 0;

    always @(posedge clk) begin
        #1;
        if (rdy_pat.size() != 0) m_axis_tready = rdy_pat.pop_front();
        else if (rdy_rand)       m_axis_tready = M'($urandom_range(0, 3));
        else                     m_axis_tready = rdy_const;
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DSW-1:0] dest, input logic [DW-1:0] data, input logic last);
        bit acc = 0;
        int n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdest  = dest;
        s_axis_tdata  = data;
        s_axis_tkeep  = KW'($urandom);
        s_axis_tuser  = UW'($urandom);
        s_axis_tlast  = last;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_axis_tready;
            if (!acc) stalls++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_in_budget", 64'(acc), 1);
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        s_axis_tuser = '0; s_axis_tdest = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 4-beat frame to port 1
        for (int b = 0; b < 4; b++) send_beat(2'd1, 32'h1000 + b, b == 3);
        chk("lit_fc1_after_4beat", 64'(frame_count[63:32]), 1);
        chk("lit_fc0_after_4beat", 64'(frame_count[31:0]), 0);
        idle(3);

        // tdest changes mid-frame but the frame stays on port 1
        send_beat(2'd1, 32'h2000, 1'b0);
        send_beat(2'd0, 32'h2001, 1'b0);
        send_beat(2'd0, 32'h2002, 1'b1);
        idle(3);
        chk("lit_fc1_after_switch", 64'(frame_count[63:32]), 2);
        chk("lit_fc0_after_switch", 64'(frame_count[31:0]), 0);

        // out-of-range destination is discarded without back-pressure
        stalls = 0;
        for (int b = 0; b < 5; b++) send_beat(2'd3, 32'h3000 + b, b == 4);
        chk("lit_drop_nostall", 64'(stalls), 0);
        chk("lit_drop_count", 64'(drop_count), 1);
        send_beat(2'd0, 32'h3100, 1'b0);
        send_beat(2'd0, 32'h3101, 1'b1);
        idle(3);
        chk("lit_fc0_after_drop", 64'(frame_count[31:0]), 1);

        // port 0 ready toggling 1,0,0,1 while a frame streams in
        stalls = 0;
        rdy_pat.push_back(2'b11); rdy_pat.push_back(2'b10);
        rdy_pat.push_back(2'b10); rdy_pat.push_back(2'b11);
        for (int b = 0; b < 4; b++) send_beat(2'd0, 32'h4000 + b, b == 3);
        chk("lit_stall_seen", 64'(stalls != 0), 1);
        idle(3);
        chk("lit_fc0_after_toggle", 64'(frame_count[31:0]), 2);

        // stalled port 1 does not block a port 0 frame
        rdy_const = 2'b01;
        idle(2);
        send_beat(2'd1, 32'h5000, 1'b1);
        for (int b = 0; b < 3; b++) send_beat(2'd0, 32'h5100 + b, b == 2);
        chk("lit_p1_held_valid", 64'(m_axis_tvalid[1]), 1);
        chk("lit_p1_held_data", 64'(m_axis_tdata[63:32]), 64'h5000);
        rdy_const = 2'b11;
        idle(3);

        // reset in the middle of a forwarded frame
        send_beat(2'd0, 32'h6000, 1'b0);
        send_beat(2'd0, 32'h6001, 1'b0);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        send_beat(2'd0, 32'hCAFE0001, 1'b1);
        chk("lit_post_rst_valid", 64'(m_axis_tvalid[0]), 1);
        chk("lit_post_rst_data", 64'(m_axis_tdata[31:0]), 64'hCAFE0001);
        chk("lit_post_rst_last", 64'(m_axis_tlast[0]), 1);
        chk("lit_post_rst_fc0", 64'(frame_count[31:0]), 1);
        idle(3);

        // randomized traffic with random output back-pressure
        rdy_rand = 1;
        for (int f = 0; f < 40; f++) begin
            int len;
            logic [DSW-1:0] d0;
            len = $urandom_range(1, 5);
            d0  = DSW'($urandom_range(0, 3));
            for (int b = 0; b < len; b++) begin
                send_beat((b == 0) ? d0 : DSW'($urandom_range(0, 3)), $urandom, b == len - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        rdy_rand = 0;
        rdy_const = 2'b11;
        idle(10);
        chk("final_drained", 64'(m_axis_tvalid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
